// File: rtl/rgb2yuv422_pkg.sv
// Shared imager definitions: data-type codes carried alongside pixels and the
// BT.601 RGB -> YCbCr coefficient set used by the colour-space converter.
package rgb2yuv422_pkg;

  localparam int DTYPE_WIDTH = 4;

  typedef enum logic [DTYPE_WIDTH-1:0] {
    DT_NONE        = 4'h0,
    DT_FRAME_START = 4'h1,
    DT_FRAME_END   = 4'h2,
    DT_ROW_START   = 4'h3,
    DT_ROW_END     = 4'h4,
    DT_PIXEL       = 4'h8
  } dtype_e;

  // BT.601 coefficients scaled by 2^8
  localparam int Y_KR  = 77;
  localparam int Y_KG  = 150;
  localparam int Y_KB  = 29;
  localparam int CB_KR = -43;
  localparam int CB_KG = -85;
  localparam int CB_KB = 128;
  localparam int CR_KR = 128;
  localparam int CR_KG = -107;
  localparam int CR_KB = -21;

  localparam int RND   = 128;
  localparam int SHIFT = 8;

  // Extra headroom bits on top of the pixel width for the signed dot product
  localparam int SUM_XW = 10;

endpackage

// File: rtl/rgb2yuv422_dot3_clamp.sv
// Three-term signed dot product of unsigned samples with round-to-nearest,
// floor shift, constant offset and clamp to the unsigned pixel range.
module rgb_dot3_clamp
  import rgb2yuv422_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int KA          = 0,
  parameter int KB          = 0,
  parameter int KC          = 0,
  parameter int OFFSET      = 0
) (
  input  logic [PIXEL_WIDTH-1:0] a,
  input  logic [PIXEL_WIDTH-1:0] b,
  input  logic [PIXEL_WIDTH-1:0] c,
  output logic [PIXEL_WIDTH-1:0] q
);

  localparam int SW = PIXEL_WIDTH + SUM_XW;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << PIXEL_WIDTH) - 1);

  // Add the half-LSB constant and floor-shift back to pixel scale
  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] v);
    return (v + SW'(RND)) >>> SHIFT;
  endfunction

  // Saturate a signed value into [0, 2^PIXEL_WIDTH - 1]
  function automatic logic [PIXEL_WIDTH-1:0] clamp(input logic signed [SW-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAXV)
      return '1;
    else
      return v[PIXEL_WIDTH-1:0];
  endfunction

  logic signed [SW-1:0] a_s, b_s, c_s, sum, scaled;

  // Zero-extend the samples, accumulate, round, offset and clamp
  always_comb begin
    a_s    = $signed({{SUM_XW{1'b0}}, a});
    b_s    = $signed({{SUM_XW{1'b0}}, b});
    c_s    = $signed({{SUM_XW{1'b0}}, c});
    sum    = a_s * SW'(KA) + b_s * SW'(KB) + c_s * SW'(KC);
    scaled = round_shift(sum) + SW'(OFFSET);
    q      = clamp(scaled);
  end

endmodule

// File: rtl/rgb2yuv422.sv
// RGB -> YUV 4:2:2 converter. Three-stage free-running pipeline: input
// capture, colour-space dot products, chroma pair averaging and output hold.
module rgb2yuv422
  import rgb2yuv422_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0] ri,
  input  logic [PIXEL_WIDTH-1:0] gi,
  input  logic [PIXEL_WIDTH-1:0] bi,
  input  logic [15:0]            meta_datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            meta_datao,
  output logic [PIXEL_WIDTH-1:0] yo,
  output logic [PIXEL_WIDTH-1:0] co,
  output logic                   cphase
);

  localparam int W    = PIXEL_WIDTH;
  localparam int HALF = 1 << (W - 1);

  // Rounded mean of two samples
  function automatic logic [W-1:0] avg_round(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y} + (W+1)'(1);
    return s[W:1];
  endfunction

  logic                   phase_d, phase_q, first_d, first_q;
  logic                   vld_p0_d, vld_p0_q, vld_p1_d, vld_p1_q, dvo_d, dvo_q;
  logic [DTYPE_WIDTH-1:0] dtype_p0_d, dtype_p0_q, dtype_p1_d, dtype_p1_q, dtypeo_d, dtypeo_q;
  logic [15:0]            meta_p0_d, meta_p0_q, meta_p1_d, meta_p1_q, meta_datao_d, meta_datao_q;
  logic                   en_p0_d, en_p0_q, en_p1_d, en_p1_q;
  logic                   ph_p0_d, ph_p0_q, ph_p1_d, ph_p1_q;
  logic                   first_p0_d, first_p0_q, first_p1_d, first_p1_q;
  logic [W-1:0]           r_p0_d, r_p0_q, g_p0_d, g_p0_q, b_p0_d, b_p0_q;
  logic [W-1:0]           y_p1_d, y_p1_q, cb_p1_d, cb_p1_q, cr_p1_d, cr_p1_q, byp_p1_d, byp_p1_q;
  logic [W-1:0]           prev_cb_d, prev_cb_q, prev_cr_d, prev_cr_q;
  logic [W-1:0]           yo_d, yo_q, co_d, co_q;
  logic                   cphase_d, cphase_q;
  logic [W-1:0]           y_dot, cb_dot, cr_dot, cb_prev, cr_prev, c_avg;
  logic                   pix_in, pix_p1;

  rgb_dot3_clamp #(.PIXEL_WIDTH(W), .KA(Y_KR),  .KB(Y_KG),  .KC(Y_KB),  .OFFSET(0))
    u_y  (.a(r_p0_q), .b(g_p0_q), .c(b_p0_q), .q(y_dot));
  rgb_dot3_clamp #(.PIXEL_WIDTH(W), .KA(CB_KR), .KB(CB_KG), .KC(CB_KB), .OFFSET(HALF))
    u_cb (.a(r_p0_q), .b(g_p0_q), .c(b_p0_q), .q(cb_dot));
  rgb_dot3_clamp #(.PIXEL_WIDTH(W), .KA(CR_KR), .KB(CR_KG), .KC(CR_KB), .OFFSET(HALF))
    u_cr (.a(r_p0_q), .b(g_p0_q), .c(b_p0_q), .q(cr_dot));

  // Next-state for row tracking and every pipeline stage
  always_comb begin
    // ---- input -> p0: tag each pixel with its phase, first flag and mode
    pix_in  = dvi && (dtypei == DT_PIXEL);
    phase_d = phase_q;
    first_d = first_q;
    if (dvi) begin
      if (dtypei == DT_ROW_START || dtypei == DT_FRAME_START)
        phase_d = 1'b0;
      else if (pix_in)
        phase_d = ~phase_q;
      if (dtypei == DT_ROW_START)
        first_d = 1'b1;
      else if (pix_in)
        first_d = 1'b0;
    end
    vld_p0_d   = dvi;
    dtype_p0_d = dtypei;
    meta_p0_d  = meta_datai;
    en_p0_d    = enable;
    ph_p0_d    = phase_q;
    first_p0_d = first_q;
    r_p0_d     = ri;
    g_p0_d     = gi;
    b_p0_d     = bi;

    // ---- p0 -> p1: colour-space conversion and bypass selection
    vld_p1_d   = vld_p0_q;
    dtype_p1_d = dtype_p0_q;
    meta_p1_d  = meta_p0_q;
    en_p1_d    = en_p0_q;
    ph_p1_d    = ph_p0_q;
    first_p1_d = first_p0_q;
    y_p1_d     = en_p0_q ? y_dot : g_p0_q;
    cb_p1_d    = cb_dot;
    cr_p1_d    = cr_dot;
    byp_p1_d   = ph_p0_q ? b_p0_q : r_p0_q;

    // ---- p1 -> output: chroma averaging with the previous pixel of the row
    pix_p1  = vld_p1_q && (dtype_p1_q == DT_PIXEL);
    cb_prev = first_p1_q ? cb_p1_q : prev_cb_q;
    cr_prev = first_p1_q ? cr_p1_q : prev_cr_q;
    c_avg   = ph_p1_q ? avg_round(cr_p1_q, cr_prev) : avg_round(cb_p1_q, cb_prev);

    dvo_d        = vld_p1_q;
    dtypeo_d     = dtype_p1_q;
    meta_datao_d = meta_p1_q;
    yo_d         = yo_q;
    co_d         = co_q;
    cphase_d     = cphase_q;
    prev_cb_d    = prev_cb_q;
    prev_cr_d    = prev_cr_q;
    if (pix_p1) begin
      yo_d      = y_p1_q;
      co_d      = en_p1_q ? c_avg : byp_p1_q;
      cphase_d  = ph_p1_q;
      prev_cb_d = cb_p1_q;
      prev_cr_d = cr_p1_q;
    end
  end

  // Control state, valids, sideband and outputs: cleared asynchronously
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phase_q      <= 1'b0;
      first_q      <= 1'b1;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      dvo_q        <= 1'b0;
      dtype_p0_q   <= '0;
      dtype_p1_q   <= '0;
      dtypeo_q     <= '0;
      meta_p0_q    <= '0;
      meta_p1_q    <= '0;
      meta_datao_q <= '0;
      en_p0_q      <= 1'b0;
      en_p1_q      <= 1'b0;
      ph_p0_q      <= 1'b0;
      ph_p1_q      <= 1'b0;
      first_p0_q   <= 1'b1;
      first_p1_q   <= 1'b1;
      yo_q         <= '0;
      co_q         <= '0;
      cphase_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      first_q      <= first_d;
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      dvo_q        <= dvo_d;
      dtype_p0_q   <= dtype_p0_d;
      dtype_p1_q   <= dtype_p1_d;
      dtypeo_q     <= dtypeo_d;
      meta_p0_q    <= meta_p0_d;
      meta_p1_q    <= meta_p1_d;
      meta_datao_q <= meta_datao_d;
      en_p0_q      <= en_p0_d;
      en_p1_q      <= en_p1_d;
      ph_p0_q      <= ph_p0_d;
      ph_p1_q      <= ph_p1_d;
      first_p0_q   <= first_p0_d;
      first_p1_q   <= first_p1_d;
      yo_q         <= yo_d;
      co_q         <= co_d;
      cphase_q     <= cphase_d;
    end
  end

  // Sample datapath: qualified by the valids above, so no reset needed
  always_ff @(posedge clk) begin
    r_p0_q    <= r_p0_d;
    g_p0_q    <= g_p0_d;
    b_p0_q    <= b_p0_d;
    y_p1_q    <= y_p1_d;
    cb_p1_q   <= cb_p1_d;
    cr_p1_q   <= cr_p1_d;
    byp_p1_q  <= byp_p1_d;
    prev_cb_q <= prev_cb_d;
    prev_cr_q <= prev_cr_d;
  end

  assign dvo        = dvo_q;
  assign dtypeo     = dtypeo_q;
  assign meta_datao = meta_datao_q;
  assign yo         = yo_q;
  assign co         = co_q;
  assign cphase     = cphase_q;

endmodule

// File: tb/tb_rgb2yuv422.sv
// Bench for rgb2yuv422: directed scenarios plus randomized traffic checked
// against an integer reference model of the 4:2:2 conversion.
module tb_rgb2yuv422;
  import rgb2yuv422_pkg::*;

  localparam int PW  = 10;
  localparam int MAX = 1023;
  localparam int MID = 512;

  localparam logic [DTYPE_WIDTH-1:0] T_RS  = DT_ROW_START;
  localparam logic [DTYPE_WIDTH-1:0] T_FS  = DT_FRAME_START;
  localparam logic [DTYPE_WIDTH-1:0] T_RE  = DT_ROW_END;
  localparam logic [DTYPE_WIDTH-1:0] T_FE  = DT_FRAME_END;
  localparam logic [DTYPE_WIDTH-1:0] T_PIX = DT_PIXEL;
  localparam logic [DTYPE_WIDTH-1:0] T_NO  = DT_NONE;

  logic                   clk = 1'b0;
  logic                   resetb, enable, dvi;
  logic [DTYPE_WIDTH-1:0] dtypei;
  logic [PW-1:0]          ri, gi, bi;
  logic [15:0]            meta_datai;
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0]            meta_datao;
  logic [PW-1:0]          yo, co;
  logic                   cphase;

  always #5 clk = ~clk;

  rgb2yuv422 #(.PIXEL_WIDTH(PW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .ri(ri), .gi(gi), .bi(bi), .meta_datai(meta_datai),
    .dvo(dvo), .dtypeo(dtypeo), .meta_datao(meta_datao),
    .yo(yo), .co(co), .cphase(cphase)
  );

  typedef struct {
    logic                   dv;
    logic [DTYPE_WIDTH-1:0] dt;
    logic [15:0]            meta;
    int                     y;
    int                     c;
    logic                   cp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic m_phase, m_first, m_cp;
  int   m_y, m_c, pcb, pcr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > MAX) ? MAX : v);
  endfunction

  // Reference: what the outputs must show three clocks after this input
  task automatic model(input logic dv, input logic [DTYPE_WIDTH-1:0] dt,
                       input logic [15:0] meta, input logic en,
                       input int r, input int g, input int b);
    int yv, cbv, crv;
    exp_t e;
    if (dv && dt == T_PIX) begin
      yv  = clampi((77 * r + 150 * g + 29 * b + 128) >>> 8);
      cbv = clampi(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + MID);
      crv = clampi(((128 * r - 107 * g - 21 * b + 128) >>> 8) + MID);
      if (m_first) begin
        pcb = cbv;
        pcr = crv;
      end
      if (en) begin
        m_y = yv;
        m_c = m_phase ? (crv + pcr + 1) / 2 : (cbv + pcb + 1) / 2;
      end else begin
        m_y = g;
        m_c = m_phase ? b : r;
      end
      m_cp    = m_phase;
      pcb     = cbv;
      pcr     = crv;
      m_first = 1'b0;
      m_phase = ~m_phase;
    end else if (dv && dt == T_RS) begin
      m_phase = 1'b0;
      m_first = 1'b1;
    end else if (dv && dt == T_FS) begin
      m_phase = 1'b0;
    end
    e.dv = dv; e.dt = dt; e.meta = meta; e.y = m_y; e.c = m_c; e.cp = m_cp;
    q.push_back(e);
  endtask

  task automatic model_reset();
    exp_t z;
    q.delete();
    m_phase = 1'b0; m_first = 1'b1; m_cp = 1'b0; m_y = 0; m_c = 0;
    z.dv = 1'b0; z.dt = '0; z.meta = '0; z.y = 0; z.c = 0; z.cp = 1'b0;
    q.push_back(z);
    q.push_back(z);
  endtask

  // One clock of stimulus; afterwards compare against the oldest expectation
  task automatic step(input logic dv, input logic [DTYPE_WIDTH-1:0] dt,
                      input int r, input int g, input int b);
    exp_t e;
    @(negedge clk);
    dvi        = dv;
    dtypei     = dt;
    ri         = PW'(r);
    gi         = PW'(g);
    bi         = PW'(b);
    meta_datai = 16'($urandom);
    model(dv, dt, meta_datai, enable, r, g, b);
    @(posedge clk);
    #1;
    if (q.size() > 2) begin
      e = q.pop_front();
      chk("dvo",        32'(dvo),        32'(e.dv));
      chk("dtypeo",     32'(dtypeo),     32'(e.dt));
      chk("meta_datao", 32'(meta_datao), 32'(e.meta));
      chk("yo",         32'(yo),         32'(e.y));
      chk("co",         32'(co),         32'(e.c));
      chk("cphase",     32'(cphase),     32'(e.cp));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dvo"},    32'(dvo),        0);
    chk({tag, "_dtypeo"}, 32'(dtypeo),     0);
    chk({tag, "_meta"},   32'(meta_datao), 0);
    chk({tag, "_yo"},     32'(yo),         0);
    chk({tag, "_co"},     32'(co),         0);
    chk({tag, "_cphase"}, 32'(cphase),     0);
  endtask

  // Called just after a step: drop reset between edges, release between edges
  task automatic pulse_reset();
    dvi    = 1'b0;
    resetb = 1'b0;
    #1;
    check_zero_outputs("rst_async");
    @(posedge clk);
    #2;
    resetb = 1'b1;
    model_reset();
  endtask

  task automatic idle2();
    step(1'b0, T_NO, 0, 0, 0);
    step(1'b0, T_NO, 0, 0, 0);
  endtask

  function automatic int rand_pix();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return MAX;
      default: return int'($urandom_range(0, MAX));
    endcase
  endfunction

  initial begin
    int k;
    logic dv;
    logic [DTYPE_WIDTH-1:0] dt;

    resetb = 1'b1; enable = 1'b1; dvi = 1'b0; dtypei = '0;
    ri = '0; gi = '0; bi = '0; meta_datai = '0;
    #1 resetb = 1'b0;
    #1;
    check_zero_outputs("reset");
    @(posedge clk);
    #2;
    resetb = 1'b1;
    model_reset();

    // white pixel at start of row
    step(1'b1, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, MAX, MAX, MAX);
    idle2();
    chk("white_dvo", 32'(dvo), 1);
    chk("white_yo",  32'(yo), 1023);
    chk("white_co",  32'(co), 512);
    chk("white_cph", 32'(cphase), 0);

    // white, red, black
    step(1'b1, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, MAX, MAX, MAX);
    step(1'b1, T_PIX, MAX, 0, 0);
    step(1'b1, T_PIX, 0, 0, 0);
    step(1'b0, T_NO, 0, 0, 0);
    chk("red_yo",  32'(yo), 308);
    chk("red_co",  32'(co), 768);
    chk("red_cph", 32'(cphase), 1);
    step(1'b0, T_NO, 0, 0, 0);
    chk("black_yo",  32'(yo), 0);
    chk("black_co",  32'(co), 426);
    chk("black_cph", 32'(cphase), 0);

    // Cr clamp: red after red on odd phase
    step(1'b1, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, MAX, 0, 0);
    step(1'b1, T_PIX, MAX, 0, 0);
    idle2();
    chk("crclamp_yo",  32'(yo), 308);
    chk("crclamp_co",  32'(co), 1023);
    chk("crclamp_cph", 32'(cphase), 1);

    // bypass
    enable = 1'b0;
    step(1'b1, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, 10, 20, 30);
    step(1'b1, T_PIX, 10, 20, 30);
    step(1'b0, T_NO, 0, 0, 0);
    chk("byp_even_yo",  32'(yo), 20);
    chk("byp_even_co",  32'(co), 10);
    chk("byp_even_cph", 32'(cphase), 0);
    step(1'b0, T_NO, 0, 0, 0);
    chk("byp_odd_yo",  32'(yo), 20);
    chk("byp_odd_co",  32'(co), 30);
    chk("byp_odd_cph", 32'(cphase), 1);
    enable = 1'b1;

    // gaps between pixels
    step(1'b1, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, MAX, MAX, MAX);
    step(1'b0, T_PIX, 5, 5, 5);
    step(1'b0, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, MAX, 0, 0);
    idle2();
    chk("gap_red_yo",  32'(yo), 308);
    chk("gap_red_co",  32'(co), 768);
    chk("gap_red_cph", 32'(cphase), 1);

    // reset mid-row with a pixel in flight
    step(1'b1, T_RS, 0, 0, 0);
    step(1'b1, T_PIX, MAX, MAX, MAX);
    step(1'b1, T_PIX, 0, MAX, 0);
    pulse_reset();
    step(1'b1, T_PIX, MAX, 0, 0);
    idle2();
    chk("postrst_dvo", 32'(dvo), 1);
    chk("postrst_yo",  32'(yo), 308);
    chk("postrst_co",  32'(co), 340);
    chk("postrst_cph", 32'(cphase), 0);

    // randomized traffic
    step(1'b1, T_RS, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      dv = ($urandom_range(0, 99) < 80);
      k  = int'($urandom_range(0, 19));
      case (k)
        0:       dt = T_RS;
        1:       dt = T_FS;
        2:       dt = T_RE;
        3:       dt = T_FE;
        default: dt = T_PIX;
      endcase
      if ($urandom_range(0, 19) == 0)
        enable = ~enable;
      step(dv, dt, rand_pix(), rand_pix(), rand_pix());
      if (i == 300)
        pulse_reset();
    end
    idle2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
